// File: rtl/nonce_ctrl_if.sv
// Purpose: handshake bundle between the nonce sequencer and its neighbours
//          (comparator verdicts in, nonce/launch/status out).
// Signals:
//   start        request a new search
//   valid        comparator: current hash meets target
//   next         comparator: current hash fails, try the next nonce
//   nonce        nonce presented to the hash core
//   hash_start   one-cycle launch pulse for the hash core
//   busy         search in progress
//   found        golden nonce captured
//   done         search finished (found or exhausted)
//   golden_nonce nonce that produced valid
// Modports: slave = the sequencer, master = whoever drives start/verdicts.
interface nonce_ctrl_if #(
    parameter int NONCE_W = 32
) ();
    logic               start;
    logic               valid;
    logic               next;
    logic [NONCE_W-1:0] nonce;
    logic               hash_start;
    logic               busy;
    logic               found;
    logic               done;
    logic [NONCE_W-1:0] golden_nonce;

    modport master (
        output start, valid, next,
        input  nonce, hash_start, busy, found, done, golden_nonce
    );

    modport slave (
        input  start, valid, next,
        output nonce, hash_start, busy, found, done, golden_nonce
    );
endinterface

// File: rtl/nonce_ctrl.sv
// Purpose: nonce sequencer sitting after the hash-target comparator. It
//          launches a hash on each nonce, steps to the next nonce on a miss,
//          captures the golden nonce on a hit and stops, or stops at
//          NONCE_MAX when the range is exhausted.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low
//   bus    nonce_ctrl_if.slave (start/valid/next in; nonce, hash_start,
//          busy, found, done, golden_nonce out; all outputs registered)
// Build option: define TIMEOUT_EN to add a watchdog that re-launches the
//          same nonce after TIMEOUT_CYC silent cycles in WAIT.
module nonce_ctrl #(
    parameter int                 NONCE_W    = 32,
    parameter logic [NONCE_W-1:0] NONCE_INIT = {NONCE_W{1'b0}},
    parameter logic [NONCE_W-1:0] NONCE_MAX  = {NONCE_W{1'b1}}
`ifdef TIMEOUT_EN
    ,parameter int                TIMEOUT_CYC = 64
`endif
) (
    input logic         clk,
    input logic         reset,
    nonce_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_FOUND   = 3'd3,
        S_EXHAUST = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [NONCE_W-1:0] nonce_r;
    logic [NONCE_W-1:0] golden_r;
    logic               hash_start_r;
    logic               busy_r;
    logic               found_r;
    logic               done_r;

    logic [NONCE_W-1:0] nonce_nxt_s;
    logic [NONCE_W-1:0] golden_nxt_s;
    logic               hash_start_nxt_s;
    logic               busy_nxt_s;
    logic               found_nxt_s;
    logic               done_nxt_s;

    logic               restart_s;
    logic               hit_s;
    logic               miss_s;
    logic               at_end_s;
    logic               exhaust_s;
    logic               advance_s;
    logic               timeout_s;

    // Start is honoured only when no search is running.
    assign restart_s = ((state_r == S_IDLE) || (state_r == S_FOUND) ||
                        (state_r == S_EXHAUST)) && bus.start;
    // Verdicts count only in WAIT; valid beats next when both arrive.
    assign hit_s     = (state_r == S_WAIT) && bus.valid;
    assign miss_s    = (state_r == S_WAIT) && !bus.valid && bus.next;
    // ">=" also covers NONCE_INIT above NONCE_MAX: the first miss ends it.
    assign at_end_s  = (nonce_r >= NONCE_MAX);
    assign exhaust_s = miss_s && at_end_s;
    assign advance_s = miss_s && !at_end_s;

`ifdef TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_r;

    // Watchdog: counts WAIT cycles, cleared whenever we are not waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == S_WAIT) begin
            wd_r <= wd_r + WD_W'(1);
        end else begin
            wd_r <= {WD_W{1'b0}};
        end
    end

    // Fires on the last silent WAIT cycle so LAUNCH+WAIT spans TIMEOUT_CYC+1.
    assign timeout_s = (state_r == S_WAIT) && !bus.valid && !bus.next &&
                       (wd_r == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_FOUND, S_EXHAUST: begin
                if (bus.start) begin
                    state_nxt_s = S_LAUNCH;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LAUNCH: begin
                state_nxt_s = S_WAIT;
            end
            S_WAIT: begin
                if (hit_s) begin
                    state_nxt_s = S_FOUND;
                end else if (exhaust_s) begin
                    state_nxt_s = S_EXHAUST;
                end else if (advance_s || timeout_s) begin
                    state_nxt_s = S_LAUNCH;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        nonce_nxt_s      = nonce_r;
        golden_nxt_s     = golden_r;
        found_nxt_s      = found_r;
        done_nxt_s       = done_r;
        hash_start_nxt_s = (state_nxt_s == S_LAUNCH);
        busy_nxt_s       = (state_nxt_s == S_LAUNCH) || (state_nxt_s == S_WAIT);
        if (restart_s) begin
            nonce_nxt_s = NONCE_INIT;
            found_nxt_s = 1'b0;
            done_nxt_s  = 1'b0;
        end else if (hit_s) begin
            golden_nxt_s = nonce_r;
            found_nxt_s  = 1'b1;
            done_nxt_s   = 1'b1;
        end else if (exhaust_s) begin
            found_nxt_s = 1'b0;
            done_nxt_s  = 1'b1;
        end else if (advance_s) begin
            nonce_nxt_s = nonce_r + NONCE_W'(1);
        end else begin
            nonce_nxt_s = nonce_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nonce_r      <= {NONCE_W{1'b0}};
            golden_r     <= {NONCE_W{1'b0}};
            hash_start_r <= 1'b0;
            busy_r       <= 1'b0;
            found_r      <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            nonce_r      <= nonce_nxt_s;
            golden_r     <= golden_nxt_s;
            hash_start_r <= hash_start_nxt_s;
            busy_r       <= busy_nxt_s;
            found_r      <= found_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign bus.nonce        = nonce_r;
    assign bus.golden_nonce = golden_r;
    assign bus.hash_start   = hash_start_r;
    assign bus.busy         = busy_r;
    assign bus.found        = found_r;
    assign bus.done         = done_r;

endmodule

// File: tb/tb_nonce_ctrl.sv
// Directed bench for nonce_ctrl. Three instances cover a normal 32-bit
// search (INIT=5), an 8-bit range ending at all-ones (INIT=FE, MAX=FF) and
// an inverted range (INIT=9 > MAX=3, 4-bit) which also carries the
// watchdog check when TIMEOUT_EN is defined.
module tb_nonce_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    nonce_ctrl_if #(.NONCE_W(32)) ifa ();
    nonce_ctrl_if #(.NONCE_W(8))  ifb ();
    nonce_ctrl_if #(.NONCE_W(4))  ifc ();

    nonce_ctrl #(
        .NONCE_W(32), .NONCE_INIT(32'd5), .NONCE_MAX(32'hFFFF_FFFF)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    nonce_ctrl #(
        .NONCE_W(8), .NONCE_INIT(8'hFE), .NONCE_MAX(8'hFF)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

`ifdef TIMEOUT_EN
    nonce_ctrl #(
        .NONCE_W(4), .NONCE_INIT(4'd9), .NONCE_MAX(4'd3), .TIMEOUT_CYC(4)
    ) dut_c (.clk(clk), .reset(reset), .bus(ifc));
`else
    nonce_ctrl #(
        .NONCE_W(4), .NONCE_INIT(4'd9), .NONCE_MAX(4'd3)
    ) dut_c (.clk(clk), .reset(reset), .bus(ifc));
`endif

    // 100 MHz-style clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got sim time %0t expected finish earlier", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        ifa.start = 1'b0; ifa.valid = 1'b0; ifa.next = 1'b0;
        ifb.start = 1'b0; ifb.valid = 1'b0; ifb.next = 1'b0;
        ifc.start = 1'b0; ifc.valid = 1'b0; ifc.next = 1'b0;

        // Reset state.
        #2 reset = 1'b0;
        #20;
        chk("rst_a_nonce", ifa.nonce, 32'd0);
        chk("rst_a_busy",  {31'd0, ifa.busy}, 32'd0);
        chk("rst_a_hs",    {31'd0, ifa.hash_start}, 32'd0);
        chk("rst_a_found", {31'd0, ifa.found}, 32'd0);
        chk("rst_a_done",  {31'd0, ifa.done}, 32'd0);
        chk("rst_a_gold",  ifa.golden_nonce, 32'd0);
        chk("rst_b_nonce", {24'd0, ifb.nonce}, 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Launch: start at one edge gives hash_start right after it.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("t1_hs",    {31'd0, ifa.hash_start}, 32'd1);
        chk("t1_nonce", ifa.nonce, 32'd5);
        chk("t1_busy",  {31'd0, ifa.busy}, 32'd1);
        tick();
        chk("t1_hs_pulse", {31'd0, ifa.hash_start}, 32'd0);
        chk("t1_busy_w",   {31'd0, ifa.busy}, 32'd1);

        // No verdict: WAIT holds everything.
        repeat (3) tick();
        chk("hold_hs",    {31'd0, ifa.hash_start}, 32'd0);
        chk("hold_nonce", ifa.nonce, 32'd5);
        chk("hold_busy",  {31'd0, ifa.busy}, 32'd1);

        // Three misses step 5->6->7->8, each re-launching.
        for (int i = 0; i < 3; i++) begin
            ifa.next = 1'b1;
            tick();
            ifa.next = 1'b0;
            chk("t2_step_nonce", ifa.nonce, 32'd6 + 32'(i));
            chk("t2_step_hs",    {31'd0, ifa.hash_start}, 32'd1);
            tick();
            chk("t2_step_hs_lo", {31'd0, ifa.hash_start}, 32'd0);
        end
        ifa.valid = 1'b1;
        tick();
        ifa.valid = 1'b0;
        chk("t2_found", {31'd0, ifa.found}, 32'd1);
        chk("t2_done",  {31'd0, ifa.done}, 32'd1);
        chk("t2_busy",  {31'd0, ifa.busy}, 32'd0);
        chk("t2_gold",  ifa.golden_nonce, 32'd8);
        chk("t2_nonce", ifa.nonce, 32'd8);

        // Stale verdict in FOUND is ignored.
        ifa.next = 1'b1;
        tick();
        ifa.next = 1'b0;
        chk("stale_nonce", ifa.nonce, 32'd8);
        chk("stale_found", {31'd0, ifa.found}, 32'd1);
        chk("stale_hs",    {31'd0, ifa.hash_start}, 32'd0);

        // Restart from FOUND; golden value survives until a new hit.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("t4_rs_nonce", ifa.nonce, 32'd5);
        chk("t4_rs_found", {31'd0, ifa.found}, 32'd0);
        chk("t4_rs_done",  {31'd0, ifa.done}, 32'd0);
        chk("t4_rs_gold",  ifa.golden_nonce, 32'd8);
        chk("t4_rs_hs",    {31'd0, ifa.hash_start}, 32'd1);
        tick();
        // Start while busy is ignored.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("busy_start_hs",    {31'd0, ifa.hash_start}, 32'd0);
        chk("busy_start_busy",  {31'd0, ifa.busy}, 32'd1);
        // valid and next together: hit, no increment.
        ifa.valid = 1'b1;
        ifa.next  = 1'b1;
        tick();
        ifa.valid = 1'b0;
        ifa.next  = 1'b0;
        chk("t4_both_found", {31'd0, ifa.found}, 32'd1);
        chk("t4_both_nonce", ifa.nonce, 32'd5);
        chk("t4_both_gold",  ifa.golden_nonce, 32'd5);
        chk("t4_both_done",  {31'd0, ifa.done}, 32'd1);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("t4_re_nonce", ifa.nonce, 32'd5);
        chk("t4_re_found", {31'd0, ifa.found}, 32'd0);
        chk("t4_re_hs",    {31'd0, ifa.hash_start}, 32'd1);
        tick();

        // Reset mid-WAIT clears outputs without a clock edge.
        #2 reset = 1'b0;
        #1;
        chk("t5_nonce", ifa.nonce, 32'd0);
        chk("t5_busy",  {31'd0, ifa.busy}, 32'd0);
        chk("t5_gold",  ifa.golden_nonce, 32'd0);
        chk("t5_done",  {31'd0, ifa.done}, 32'd0);
        @(negedge clk) reset = 1'b1;
        ifa.valid = 1'b1;
        tick();
        tick();
        ifa.valid = 1'b0;
        chk("t5_post_found", {31'd0, ifa.found}, 32'd0);
        chk("t5_post_busy",  {31'd0, ifa.busy}, 32'd0);
        chk("t5_post_hs",    {31'd0, ifa.hash_start}, 32'd0);

        // Range ending at all-ones: FE, FF, then exhaust without wrapping.
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("t3_nonce0", {24'd0, ifb.nonce}, 32'h0000_00FE);
        tick();
        ifb.next = 1'b1;
        tick();
        ifb.next = 1'b0;
        chk("t3_nonce1", {24'd0, ifb.nonce}, 32'h0000_00FF);
        chk("t3_hs1",    {31'd0, ifb.hash_start}, 32'd1);
        tick();
        ifb.next = 1'b1;
        tick();
        ifb.next = 1'b0;
        chk("t3_done",  {31'd0, ifb.done}, 32'd1);
        chk("t3_found", {31'd0, ifb.found}, 32'd0);
        chk("t3_busy",  {31'd0, ifb.busy}, 32'd0);
        chk("t3_nonce", {24'd0, ifb.nonce}, 32'h0000_00FF);
        ifb.next = 1'b1;
        tick();
        ifb.next = 1'b0;
        chk("t3_nowrap", {24'd0, ifb.nonce}, 32'h0000_00FF);

        // Inverted range: one try, first miss exhausts.
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk("inv_nonce", {28'd0, ifc.nonce}, 32'd9);
        tick();
        ifc.next = 1'b1;
        tick();
        ifc.next = 1'b0;
        chk("inv_done",  {31'd0, ifc.done}, 32'd1);
        chk("inv_found", {31'd0, ifc.found}, 32'd0);
        chk("inv_nonce2", {28'd0, ifc.nonce}, 32'd9);

        // Watchdog behaviour (or its absence).
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk("wd_hs0", {31'd0, ifc.hash_start}, 32'd1);
`ifdef TIMEOUT_EN
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("wd_quiet", {31'd0, ifc.hash_start}, 32'd0);
            end
            tick();
            chk("wd_relaunch", {31'd0, ifc.hash_start}, 32'd1);
            chk("wd_nonce",    {28'd0, ifc.nonce}, 32'd9);
        end
`else
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("nowd_quiet", {31'd0, ifc.hash_start}, 32'd0);
        end
        chk("nowd_busy", {31'd0, ifc.busy}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
